led_array_ctrl: RTL and testbench

- Multi-channel LED driver; the parametrised successor of the single fixed-rate blinker.
- Each of NUM_LEDS channels is configured at runtime with one of five modes: OFF, ON, BLINK, PWM, BREATHE.
- A shared prescaler generates a time-base tick; a shared counter generates PWM.
- Sits between a simple config write port (driven by the board controller or testbench) and the board LED pins.

---
 rtl/led_pkg.sv | 36 +++
 rtl/led_channel.sv | 142 ++++++++++++++
 rtl/led_array_ctrl.sv | 88 ++++++++
 tb/tb_led_array_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
//   Shared types and constants for the multi-channel LED driver.
//   - mode_t       : per-channel operating mode (3-bit encoding)
//   - DEF_PERIOD   : reset value of the blink half-period (ticks)
//   - DEF_DUTY     : reset value of the PWM duty
//   - decode_mode  : maps a raw 3-bit mode field onto mode_t; unused
//                    encodings fall back to MODE_OFF
// -----------------------------------------------------------------------------
package led_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 3'd0,
    MODE_ON      = 3'd1,
    MODE_BLINK   = 3'd2,
    MODE_PWM     = 3'd3,
    MODE_BREATHE = 3'd4
  } mode_t;

  localparam int DEF_PERIOD = 1;
  localparam int DEF_DUTY   = 0;

  // Encodings 5..7 are reserved; a channel written with one of them goes dark.
  function automatic mode_t decode_mode(input logic [MODE_W-1:0] raw);
    case (raw)
      3'd1:    return MODE_ON;
      3'd2:    return MODE_BLINK;
      3'd3:    return MODE_PWM;
      3'd4:    return MODE_BREATHE;
      default: return MODE_OFF;
    endcase
  endfunction

endpackage : led_pkg

// File: rtl/led_channel.sv
// -----------------------------------------------------------------------------
// led_channel
//   One LED channel: holds its configuration (mode, blink half-period, PWM
//   duty), the blink tick counter and phase, the breathe level/direction and
//   the registered led / blink_edge outputs.
//
// Ports
//   clk, reset   : system clock, asynchronous active-high reset
//   tick_i       : shared time-base strobe (one clk wide, unregistered)
//   pwm_cnt      : shared free-running PWM counter
//   wr_en        : this channel is the target of a config write this cycle
//   cfg_mode     : raw 3-bit mode field
//   cfg_period   : blink half-period in ticks (0 is stored as 1)
//   cfg_duty     : PWM duty
//   led          : registered LED drive
//   blink_edge   : one-clk pulse on the edge where the blink phase flips;
//                  led follows the new phase one clk later
// -----------------------------------------------------------------------------
module led_channel
  import led_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int DUTY_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick_i,
  input  logic [DUTY_W-1:0]   pwm_cnt,
  input  logic                wr_en,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [DUTY_W-1:0]   cfg_duty,
  output logic                led,
  output logic                blink_edge
);

  localparam logic [DUTY_W-1:0]   LEVEL_MAX = '1;
  localparam logic [PERIOD_W-1:0] PERIOD_1  = PERIOD_W'(DEF_PERIOD);

  mode_t                mode_q,     mode_d;
  logic [PERIOD_W-1:0]  period_q,   period_d;
  logic [DUTY_W-1:0]    duty_q,     duty_d;
  logic [PERIOD_W-1:0]  count_q,    count_d;
  logic                 phase_q,    phase_d;
  logic [DUTY_W-1:0]    level_q,    level_d;
  logic                 dir_down_q, dir_down_d;
  logic                 led_d;
  logic                 edge_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    mode_d     = mode_q;
    period_d   = period_q;
    duty_d     = duty_q;
    count_d    = count_q;
    phase_d    = phase_q;
    level_d    = level_q;
    dir_down_d = dir_down_q;
    edge_d     = 1'b0;
    led_d      = 1'b0;

    // The LED is driven from the currently held state, so a freshly
    // written mode shows on the pin from the edge after the write.
    case (mode_q)
      MODE_ON:      led_d = 1'b1;
      MODE_BLINK:   led_d = phase_q;
      MODE_PWM:     led_d = (pwm_cnt < duty_q);
      MODE_BREATHE: led_d = (pwm_cnt < level_q);
      default:      led_d = 1'b0;
    endcase

    if (wr_en) begin
      // A write restarts the channel from scratch and swallows a tick that
      // lands in the same cycle.
      mode_d     = decode_mode(cfg_mode);
      period_d   = (cfg_period == '0) ? PERIOD_1 : cfg_period;
      duty_d     = cfg_duty;
      count_d    = '0;
      phase_d    = 1'b0;
      level_d    = '0;
      dir_down_d = 1'b0;
    end else if (tick_i) begin
      if (mode_q == MODE_BLINK) begin
        if (count_q == period_q - PERIOD_1) begin
          count_d = '0;
          phase_d = ~phase_q;
          edge_d  = 1'b1;
        end else begin
          count_d = count_q + PERIOD_1;
        end
      end

      if (mode_q == MODE_BREATHE) begin
        // Reflect at the endpoints on the same tick so the triangle never
        // dwells two ticks on 0 or on LEVEL_MAX.
        if (!dir_down_q) begin
          if (level_q == LEVEL_MAX) begin
            dir_down_d = 1'b1;
            level_d    = LEVEL_MAX - DUTY_W'(1);
          end else begin
            level_d    = level_q + DUTY_W'(1);
          end
        end else begin
          if (level_q == '0) begin
            dir_down_d = 1'b0;
            level_d    = DUTY_W'(1);
          end else begin
            level_d    = level_q - DUTY_W'(1);
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= MODE_OFF;
      period_q   <= PERIOD_1;
      duty_q     <= DUTY_W'(DEF_DUTY);
      count_q    <= '0;
      phase_q    <= 1'b0;
      level_q    <= '0;
      dir_down_q <= 1'b0;
      led        <= 1'b0;
      blink_edge <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      period_q   <= period_d;
      duty_q     <= duty_d;
      count_q    <= count_d;
      phase_q    <= phase_d;
      level_q    <= level_d;
      dir_down_q <= dir_down_d;
      led        <= led_d;
      blink_edge <= edge_d;
    end
  end

endmodule : led_channel

// File: rtl/led_array_ctrl.sv
// -----------------------------------------------------------------------------
// led_array_ctrl
//   Multi-channel LED driver. A shared prescaler produces a time-base tick,
//   a shared free-running counter provides the PWM reference, and NUM_LEDS
//   independent led_channel instances each run OFF / ON / BLINK / PWM /
//   BREATHE as configured through a single write port.
//
// Ports
//   clk, reset   : system clock, asynchronous active-high reset
//   cfg_we       : single-cycle config write strobe
//   cfg_sel      : target channel; indices >= NUM_LEDS are ignored
//   cfg_mode     : mode_t encoding (reserved values act as OFF)
//   cfg_period   : blink half-period in ticks
//   cfg_duty     : PWM duty
//   led          : registered LED drive, one bit per channel
//   tick         : registered time-base pulse, one clk wide
//   blink_edge   : per-channel pulse when a BLINK channel toggles
// -----------------------------------------------------------------------------
module led_array_ctrl
  import led_pkg::*;
#(
  parameter  int NUM_LEDS = 4,
  parameter  int TICK_DIV = 100000,
  parameter  int PERIOD_W = 16,
  parameter  int DUTY_W   = 8,
  localparam int SEL_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [DUTY_W-1:0]   cfg_duty,
  output logic [NUM_LEDS-1:0] led,
  output logic                tick,
  output logic [NUM_LEDS-1:0] blink_edge
);

  localparam int                 PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_TOP = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0]  presc_q;
  logic [DUTY_W-1:0]   pwm_cnt_q;
  logic                tick_i;
  logic [NUM_LEDS-1:0] wr_sel;

  assign tick_i = (presc_q == PRESC_TOP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      tick      <= 1'b0;
    end else begin
      presc_q   <= tick_i ? '0 : presc_q + PRESC_W'(1);
      pwm_cnt_q <= pwm_cnt_q + DUTY_W'(1);
      tick      <= tick_i;
    end
  end

  // One-hot channel select; an out-of-range index matches no channel.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (cfg_we && (int'(cfg_sel) == i)) wr_sel[i] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_channel #(
      .PERIOD_W (PERIOD_W),
      .DUTY_W   (DUTY_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .tick_i     (tick_i),
      .pwm_cnt    (pwm_cnt_q),
      .wr_en      (wr_sel[i]),
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .cfg_duty   (cfg_duty),
      .led        (led[i]),
      .blink_edge (blink_edge[i])
    );
  end

endmodule : led_array_ctrl

// File: tb/tb_led_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_array_ctrl
//   Bench for led_array_ctrl (NUM_LEDS=4, TICK_DIV=4, PERIOD_W=8, DUTY_W=4).
//   A cycle model predicts {led, tick, blink_edge} at every clock edge and
//   queues it; a monitor pops and compares on the falling edge. Scenario
//   tasks add directed timing checks. A second 3-channel instance exercises
//   the out-of-range channel select.
// -----------------------------------------------------------------------------
module tb_led_array_ctrl;

  localparam int NL = 4;
  localparam int TD = 4;
  localparam int PW = 8;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_sel = '0;
  logic [2:0]    cfg_mode = '0;
  logic [PW-1:0] cfg_period = '0;
  logic [DW-1:0] cfg_duty = '0;
  logic [NL-1:0] led;
  logic          tick;
  logic [NL-1:0] blink_edge;

  logic          cfg_we3 = 1'b0;
  logic [1:0]    cfg_sel3 = '0;
  logic [2:0]    led3;
  logic          tick3;
  logic [2:0]    blink_edge3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  led_array_ctrl #(.NUM_LEDS(NL), .TICK_DIV(TD), .PERIOD_W(PW), .DUTY_W(DW)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .led(led), .tick(tick), .blink_edge(blink_edge)
  );

  led_array_ctrl #(.NUM_LEDS(3), .TICK_DIV(TD), .PERIOD_W(PW), .DUTY_W(DW)) dut3 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we3), .cfg_sel(cfg_sel3),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .led(led3), .tick(tick3), .blink_edge(blink_edge3)
  );

  // ---------------- reference model ----------------
  int m_presc, m_pwm;
  int m_mode[NL], m_period[NL], m_duty[NL], m_count[NL], m_level[NL];
  bit m_phase[NL], m_down[NL];
  logic [NL-1:0] m_led, m_be;
  logic m_tick;
  logic [2*NL:0] exp_q[$];

  task automatic model_reset();
    m_presc = 0; m_pwm = 0; m_tick = 1'b0; m_led = '0; m_be = '0;
    for (int i = 0; i < NL; i++) begin
      m_mode[i] = 0; m_period[i] = 1; m_duty[i] = 0; m_count[i] = 0;
      m_level[i] = 0; m_phase[i] = 1'b0; m_down[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit ti;
    ti = (m_presc == TD - 1);
    for (int i = 0; i < NL; i++) begin
      case (m_mode[i])
        1:       m_led[i] = 1'b1;
        2:       m_led[i] = m_phase[i];
        3:       m_led[i] = (m_pwm < m_duty[i]);
        4:       m_led[i] = (m_pwm < m_level[i]);
        default: m_led[i] = 1'b0;
      endcase
    end
    m_tick  = ti;
    m_presc = ti ? 0 : m_presc + 1;
    m_pwm   = (m_pwm + 1) % (1 << DW);
    for (int i = 0; i < NL; i++) begin
      m_be[i] = 1'b0;
      if (cfg_we && int'(cfg_sel) == i) begin
        m_mode[i]   = (int'(cfg_mode) > 4) ? 0 : int'(cfg_mode);
        m_period[i] = (cfg_period == 0) ? 1 : int'(cfg_period);
        m_duty[i]   = int'(cfg_duty);
        m_count[i]  = 0; m_phase[i] = 1'b0; m_level[i] = 0; m_down[i] = 1'b0;
      end else if (ti) begin
        if (m_mode[i] == 2) begin
          m_count[i]++;
          if (m_count[i] == m_period[i]) begin
            m_count[i] = 0; m_phase[i] = ~m_phase[i]; m_be[i] = 1'b1;
          end
        end
        if (m_mode[i] == 4) begin
          if (!m_down[i]) begin
            if (m_level[i] == (1 << DW) - 1) begin m_down[i] = 1'b1; m_level[i]--; end
            else m_level[i]++;
          end else begin
            if (m_level[i] == 0) begin m_down[i] = 1'b0; m_level[i] = 1; end
            else m_level[i]--;
          end
        end
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset();
      exp_q.delete();
    end else begin
      model_step();
      exp_q.push_back({m_led, m_tick, m_be});
    end
  end

  always @(negedge clk) begin
    if (!reset && exp_q.size() > 0) begin
      logic [2*NL:0] exp_v;
      exp_v = exp_q.pop_front();
      vectors++;
      if ({led, tick, blink_edge} !== exp_v) begin
        miscompares++;
        $display("FAIL scoreboard t=%0t got led=%b tick=%b be=%b, want led=%b tick=%b be=%b",
                 $time, led, tick, blink_edge, exp_v[2*NL:NL+1], exp_v[NL], exp_v[NL-1:0]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; the write lands on the next rising edge.
  task automatic write_cfg(input int sel, input int mode, input int period, input int duty);
    cfg_sel = 2'(sel); cfg_mode = 3'(mode); cfg_period = PW'(period); cfg_duty = DW'(duty);
    cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Returns on a falling edge with tick high, i.e. prescaler just wrapped to 0.
  task automatic wait_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (tick !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_tick: tick=%b after %0d clks, want 1 within 16", tick, n);
    end
  endtask

  task automatic count_high(input int bit_i, input int n, output int highs);
    highs = 0;
    repeat (n) begin
      @(negedge clk);
      if (led[bit_i] === 1'b1) highs++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step(3);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      vectors++;
      if (tick !== ((k % 4) == 0) || led !== '0) begin
        miscompares++;
        $display("FAIL reset_tick edge %0d: tick=%b led=%b, want tick=%b led=0000",
                 k, tick, led, ((k % 4) == 0));
      end
    end
    write_cfg(0, 1, 1, 0);
    step(1);
    wait_tick();
    vectors++;
    if (led !== 4'b0001) begin
      miscompares++;
      $display("FAIL pre_reset led=%b, want 0001", led);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (led !== '0 || tick !== 1'b0 || blink_edge !== '0) begin
      miscompares++;
      $display("FAIL async_reset led=%b tick=%b be=%b, want all 0", led, tick, blink_edge);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_blink();
    wait_tick();
    write_cfg(1, 2, 2, 0);
    step(7);
    vectors++;
    if (blink_edge[1] !== 1'b1 || led[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL blink_first_edge be=%b led=%b, want be[1]=1 led[1]=0", blink_edge, led);
    end
    step(1);
    vectors++;
    if (led !== 4'b0010 || blink_edge !== '0) begin
      miscompares++;
      $display("FAIL blink_rise led=%b be=%b, want led=0010 be=0000", led, blink_edge);
    end
    step(7);
    vectors++;
    if (blink_edge !== 4'b0010) begin
      miscompares++;
      $display("FAIL blink_second_edge be=%b, want 0010", blink_edge);
    end
    step(1);
    vectors++;
    if (led !== 4'b0000) begin
      miscompares++;
      $display("FAIL blink_fall led=%b, want 0000", led);
    end
  endtask

  task automatic test_pwm();
    int highs;
    int duties[3] = '{5, 0, 15};
    foreach (duties[d]) begin
      write_cfg(2, 3, 1, duties[d]);
      step(1);
      count_high(2, 16, highs);
      vectors++;
      if (highs !== duties[d]) begin
        miscompares++;
        $display("FAIL pwm_duty%0d highs=%0d, want %0d of 16", duties[d], highs, duties[d]);
      end
    end
  endtask

  task automatic test_breathe();
    int highs;
    write_cfg(3, 4, 1, 0);
    count_high(3, 4, highs);
    vectors++;
    if (highs !== 0) begin
      miscompares++;
      $display("FAIL breathe_start highs=%0d, want 0", highs);
    end
    step(2 * 15 * TD + 8);
  endtask

  task automatic test_edge_cases();
    wait_tick();
    write_cfg(0, 2, 0, 0);
    step(3);
    vectors++;
    if (blink_edge[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL period0_edge be=%b, want be[0]=1", blink_edge);
    end
    step(1);
    vectors++;
    if (led[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL period0_rise led=%b, want led[0]=1", led);
    end
    step(4);
    vectors++;
    if (led[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL period0_fall led=%b, want led[0]=0", led);
    end

    write_cfg(0, 1, 1, 0);
    step(2);
    write_cfg(0, 7, 1, 0);
    step(1);
    vectors++;
    if (led[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL mode7_off led=%b, want led[0]=0", led);
    end

    // Write on the edge that samples tick_i.
    wait_tick();
    step(3);
    write_cfg(1, 2, 2, 0);
    step(7);
    vectors++;
    if (blink_edge[1] !== 1'b0 || led[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL coincident_early be=%b led=%b, want be[1]=0 led[1]=0", blink_edge, led);
    end
    step(1);
    vectors++;
    if (blink_edge[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL coincident_edge be=%b, want be[1]=1", blink_edge);
    end
    step(1);
    vectors++;
    if (led[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL coincident_rise led=%b, want led[1]=1", led);
    end
  endtask

  task automatic test_sel_range();
    cfg_mode = 3'd1; cfg_period = PW'(1); cfg_duty = '0;
    cfg_sel3 = 2'd3; cfg_we3 = 1'b1;
    @(negedge clk);
    cfg_we3 = 1'b0;
    step(2);
    vectors++;
    if (led3 !== 3'b000) begin
      miscompares++;
      $display("FAIL sel_out_of_range led3=%b, want 000", led3);
    end
    cfg_sel3 = 2'd2; cfg_we3 = 1'b1;
    @(negedge clk);
    cfg_we3 = 1'b0;
    step(2);
    vectors++;
    if (led3 !== 3'b100) begin
      miscompares++;
      $display("FAIL sel_in_range led3=%b, want 100", led3);
    end
  endtask

  task automatic test_rewrite();
    wait_tick();
    vectors++;
    if (led[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL rewrite_pre led=%b, want led[1]=1", led);
    end
    write_cfg(1, 2, 3, 0);
    step(1);
    vectors++;
    if (led[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL rewrite_drop led=%b, want led[1]=0", led);
    end
    step(10);
    vectors++;
    if (led[1] !== 1'b0 || blink_edge[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL rewrite_edge led=%b be=%b, want led[1]=0 be[1]=1", led, blink_edge);
    end
    step(1);
    vectors++;
    if (led[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL rewrite_rise led=%b, want led[1]=1", led);
    end
  endtask

  task automatic test_back_to_back();
    int highs;
    write_cfg(0, 3, 1, 8);
    write_cfg(3, 1, 1, 0);
    step(1);
    vectors++;
    if (led[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_on led=%b, want led[3]=1", led);
    end
    count_high(0, 16, highs);
    vectors++;
    if (highs !== 8) begin
      miscompares++;
      $display("FAIL b2b_pwm highs=%0d, want 8 of 16", highs);
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_pwm();
    test_breathe();
    test_edge_cases();
    test_rewrite();
    test_sel_range();
    test_back_to_back();
    step(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_led_array_ctrl
